control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 82 ++++++++
 rtl/instr_decode.sv | 56 +++++
 rtl/control_unit.sv | 175 +++++++++++++++++
 tb/tb_control_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcodes, FSM state encoding, ALU/bus select codes and
//               the control-strobe bundle used by control_unit and data_path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [7:0] c_OP_LDA_IMM = 8'h86;
    localparam logic [7:0] c_OP_LDA_DIR = 8'h87;
    localparam logic [7:0] c_OP_LDB_IMM = 8'h88;
    localparam logic [7:0] c_OP_LDB_DIR = 8'h89;
    localparam logic [7:0] c_OP_STA_DIR = 8'h96;
    localparam logic [7:0] c_OP_STB_DIR = 8'h97;
    localparam logic [7:0] c_OP_ADD_AB  = 8'h42;
    localparam logic [7:0] c_OP_SUB_AB  = 8'h43;
    localparam logic [7:0] c_OP_AND_AB  = 8'h44;
    localparam logic [7:0] c_OP_OR_AB   = 8'h45;
    localparam logic [7:0] c_OP_BRA     = 8'h20;
    localparam logic [7:0] c_OP_BEQ     = 8'h23;
    localparam logic [7:0] c_OP_BMI     = 8'h21;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b010;
    localparam logic [2:0] c_ALU_AND = 3'b100;
    localparam logic [2:0] c_ALU_OR  = 3'b101;

    localparam logic [1:0] c_BUS1_PC = 2'b00;
    localparam logic [1:0] c_BUS1_A  = 2'b01;
    localparam logic [1:0] c_BUS1_B  = 2'b10;

    localparam logic [1:0] c_BUS2_ALU  = 2'b00;
    localparam logic [1:0] c_BUS2_BUS1 = 2'b01;
    localparam logic [1:0] c_BUS2_MEM  = 2'b10;

    // CCR_Result bit positions: {N,Z,V,C}
    localparam int c_FLAG_N = 3;
    localparam int c_FLAG_Z = 2;

    localparam int c_STATE_W = 6;

    typedef enum logic [c_STATE_W-1:0] {
        S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
        S_LDA_IMM_4, S_LDA_IMM_5, S_LDA_IMM_6,
        S_LDB_IMM_4, S_LDB_IMM_5, S_LDB_IMM_6,
        S_LDA_DIR_4, S_LDA_DIR_5, S_LDA_DIR_6, S_LDA_DIR_7, S_LDA_DIR_8,
        S_LDB_DIR_4, S_LDB_DIR_5, S_LDB_DIR_6, S_LDB_DIR_7, S_LDB_DIR_8,
        S_STA_DIR_4, S_STA_DIR_5, S_STA_DIR_6, S_STA_DIR_7,
        S_STB_DIR_4, S_STB_DIR_5, S_STB_DIR_6, S_STB_DIR_7,
        S_ADD_AB_4, S_SUB_AB_4, S_AND_AB_4, S_OR_AB_4,
        S_BRA_4, S_BRA_5, S_BRA_6, S_BCC_4
    } state_t;

    typedef struct packed {
        logic       ir_load;
        logic       mar_load;
        logic       pc_load;
        logic       pc_inc;
        logic       a_load;
        logic       b_load;
        logic       ccr_load;
        logic [2:0] alu_sel;
        logic [1:0] bus1_sel;
        logic [1:0] bus2_sel;
        logic       write;
    } ctrl_t;

    // MAR <- PC: the address-phase pattern shared by fetch and most operands
    function automatic ctrl_t f_mar_from_pc();
        ctrl_t ctrl;
        ctrl          = '0;
        ctrl.bus1_sel = c_BUS1_PC;
        ctrl.bus2_sel = c_BUS2_BUS1;
        ctrl.mar_load = 1'b1;
        return ctrl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decode.sv
// ============================================================================
// Module      : instr_decode
// Description : Combinational opcode decode to the first execute state.
//               Macro BRANCH_COND_EN enables BEQ/BMI condition evaluation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decode
    import cpu_pkg::*;
(
    input  logic [7:0] i_ir,
    input  logic [3:0] i_ccr,
`ifdef BRANCH_COND_EN
    output logic       o_branch_taken,
`endif
    output state_t     o_entry_state
);

    always_comb begin
        o_entry_state = S_FETCH_0;
        case (i_ir)
            c_OP_LDA_IMM: o_entry_state = S_LDA_IMM_4;
            c_OP_LDA_DIR: o_entry_state = S_LDA_DIR_4;
            c_OP_LDB_IMM: o_entry_state = S_LDB_IMM_4;
            c_OP_LDB_DIR: o_entry_state = S_LDB_DIR_4;
            c_OP_STA_DIR: o_entry_state = S_STA_DIR_4;
            c_OP_STB_DIR: o_entry_state = S_STB_DIR_4;
            c_OP_ADD_AB:  o_entry_state = S_ADD_AB_4;
            c_OP_SUB_AB:  o_entry_state = S_SUB_AB_4;
            c_OP_AND_AB:  o_entry_state = S_AND_AB_4;
            c_OP_OR_AB:   o_entry_state = S_OR_AB_4;
            c_OP_BRA:     o_entry_state = S_BRA_4;
`ifdef BRANCH_COND_EN
            c_OP_BEQ,
            c_OP_BMI:     o_entry_state = S_BCC_4;
`endif
            default:      o_entry_state = S_FETCH_0;
        endcase
    end

`ifdef BRANCH_COND_EN
    assign o_branch_taken = ((i_ir == c_OP_BEQ) && i_ccr[c_FLAG_Z]) ||
                            ((i_ir == c_OP_BMI) && i_ccr[c_FLAG_N]);

    logic w_unused_flags;
    assign w_unused_flags = ^i_ccr[1:0];
`else
    // Flags only matter for conditional branches
    logic w_unused_flags;
    assign w_unused_flags = ^i_ccr;
`endif

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : Moore FSM sequencing fetch/decode/execute strobes for the CPU
//               datapath. Macro BRANCH_COND_EN enables BEQ/BMI.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic       CCR_Load,
    output logic [2:0] ALU_Sel,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic       write
);

    state_t r_state;
    state_t w_next_state;
    state_t w_entry_state;
    ctrl_t  w_ctrl;
    ctrl_t  w_out;

`ifdef BRANCH_COND_EN
    logic w_branch_taken;
    logic r_branch_taken;

    instr_decode u_instr_decode (
        .i_ir           (IR),
        .i_ccr          (CCR_Result),
        .o_branch_taken (w_branch_taken),
        .o_entry_state  (w_entry_state)
    );

    // Condition is frozen at decode so later flag changes cannot redirect it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_branch_taken <= 1'b0;
        else if (r_state == S_DECODE_3)
            r_branch_taken <= w_branch_taken;
    end
`else
    instr_decode u_instr_decode (
        .i_ir          (IR),
        .i_ccr         (CCR_Result),
        .o_entry_state (w_entry_state)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_FETCH_0;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = S_FETCH_0;
        w_ctrl       = '0;
        case (r_state)
            S_FETCH_0:   begin w_ctrl = f_mar_from_pc(); w_next_state = S_FETCH_1; end
            S_FETCH_1:   begin w_ctrl.pc_inc = 1'b1; w_next_state = S_FETCH_2; end
            S_FETCH_2:   begin
                w_ctrl.bus2_sel = c_BUS2_MEM;
                w_ctrl.ir_load  = 1'b1;
                w_next_state    = S_DECODE_3;
            end
            S_DECODE_3:  w_next_state = w_entry_state;

            S_LDA_IMM_4: begin w_ctrl = f_mar_from_pc(); w_next_state = S_LDA_IMM_5; end
            S_LDA_IMM_5: begin w_ctrl.pc_inc = 1'b1; w_next_state = S_LDA_IMM_6; end
            S_LDA_IMM_6: begin w_ctrl.bus2_sel = c_BUS2_MEM; w_ctrl.a_load = 1'b1; end

            S_LDB_IMM_4: begin w_ctrl = f_mar_from_pc(); w_next_state = S_LDB_IMM_5; end
            S_LDB_IMM_5: begin w_ctrl.pc_inc = 1'b1; w_next_state = S_LDB_IMM_6; end
            S_LDB_IMM_6: begin w_ctrl.bus2_sel = c_BUS2_MEM; w_ctrl.b_load = 1'b1; end

            // Direct modes: operand byte becomes the effective address in MAR
            S_LDA_DIR_4: begin w_ctrl = f_mar_from_pc(); w_next_state = S_LDA_DIR_5; end
            S_LDA_DIR_5: begin w_ctrl.pc_inc = 1'b1; w_next_state = S_LDA_DIR_6; end
            S_LDA_DIR_6: begin
                w_ctrl.bus2_sel = c_BUS2_MEM;
                w_ctrl.mar_load = 1'b1;
                w_next_state    = S_LDA_DIR_7;
            end
            S_LDA_DIR_7: w_next_state = S_LDA_DIR_8;
            S_LDA_DIR_8: begin w_ctrl.bus2_sel = c_BUS2_MEM; w_ctrl.a_load = 1'b1; end

            S_LDB_DIR_4: begin w_ctrl = f_mar_from_pc(); w_next_state = S_LDB_DIR_5; end
            S_LDB_DIR_5: begin w_ctrl.pc_inc = 1'b1; w_next_state = S_LDB_DIR_6; end
            S_LDB_DIR_6: begin
                w_ctrl.bus2_sel = c_BUS2_MEM;
                w_ctrl.mar_load = 1'b1;
                w_next_state    = S_LDB_DIR_7;
            end
            S_LDB_DIR_7: w_next_state = S_LDB_DIR_8;
            S_LDB_DIR_8: begin w_ctrl.bus2_sel = c_BUS2_MEM; w_ctrl.b_load = 1'b1; end

            S_STA_DIR_4: begin w_ctrl = f_mar_from_pc(); w_next_state = S_STA_DIR_5; end
            S_STA_DIR_5: begin w_ctrl.pc_inc = 1'b1; w_next_state = S_STA_DIR_6; end
            S_STA_DIR_6: begin
                w_ctrl.bus2_sel = c_BUS2_MEM;
                w_ctrl.mar_load = 1'b1;
                w_next_state    = S_STA_DIR_7;
            end
            S_STA_DIR_7: begin w_ctrl.bus1_sel = c_BUS1_A; w_ctrl.write = 1'b1; end

            S_STB_DIR_4: begin w_ctrl = f_mar_from_pc(); w_next_state = S_STB_DIR_5; end
            S_STB_DIR_5: begin w_ctrl.pc_inc = 1'b1; w_next_state = S_STB_DIR_6; end
            S_STB_DIR_6: begin
                w_ctrl.bus2_sel = c_BUS2_MEM;
                w_ctrl.mar_load = 1'b1;
                w_next_state    = S_STB_DIR_7;
            end
            S_STB_DIR_7: begin w_ctrl.bus1_sel = c_BUS1_B; w_ctrl.write = 1'b1; end

            S_ADD_AB_4, S_SUB_AB_4, S_AND_AB_4, S_OR_AB_4: begin
                w_ctrl.bus1_sel = c_BUS1_B;
                w_ctrl.bus2_sel = c_BUS2_ALU;
                w_ctrl.a_load   = 1'b1;
                w_ctrl.ccr_load = 1'b1;
                case (r_state)
                    S_SUB_AB_4: w_ctrl.alu_sel = c_ALU_SUB;
                    S_AND_AB_4: w_ctrl.alu_sel = c_ALU_AND;
                    S_OR_AB_4:  w_ctrl.alu_sel = c_ALU_OR;
                    default:    w_ctrl.alu_sel = c_ALU_ADD;
                endcase
            end

            S_BRA_4:     begin w_ctrl = f_mar_from_pc(); w_next_state = S_BRA_5; end
            S_BRA_5:     w_next_state = S_BRA_6;
            S_BRA_6:     begin w_ctrl.bus2_sel = c_BUS2_MEM; w_ctrl.pc_load = 1'b1; end
`ifdef BRANCH_COND_EN
            S_BCC_4: begin
                if (r_branch_taken) begin
                    w_ctrl       = f_mar_from_pc();
                    w_next_state = S_BRA_5;
                end else begin
                    w_ctrl.pc_inc = 1'b1;
                end
            end
`endif
            default:     w_next_state = S_FETCH_0;
        endcase
    end

    // Reset silences every strobe at once, without waiting for a clock edge
    assign w_out = reset ? '0 : w_ctrl;

    assign IR_Load  = w_out.ir_load;
    assign MAR_Load = w_out.mar_load;
    assign PC_Load  = w_out.pc_load;
    assign PC_Inc   = w_out.pc_inc;
    assign A_Load   = w_out.a_load;
    assign B_Load   = w_out.b_load;
    assign CCR_Load = w_out.ccr_load;
    assign ALU_Sel  = w_out.alu_sel;
    assign Bus1_Sel = w_out.bus1_sel;
    assign Bus2_Sel = w_out.bus2_sel;
    assign write    = w_out.write;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module      : tb_control_unit
// Description : Directed self-checking bench for control_unit; follows the
//               BRANCH_COND_EN build of the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;
    logic       write;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .IR         (IR),
        .CCR_Result (CCR_Result),
        .IR_Load    (IR_Load),
        .MAR_Load   (MAR_Load),
        .PC_Load    (PC_Load),
        .PC_Inc     (PC_Inc),
        .A_Load     (A_Load),
        .B_Load     (B_Load),
        .CCR_Load   (CCR_Load),
        .ALU_Sel    (ALU_Sel),
        .Bus1_Sel   (Bus1_Sel),
        .Bus2_Sel   (Bus2_Sel),
        .write      (write)
    );

    // {IR_Load,MAR_Load,PC_Load,PC_Inc,A_Load,B_Load,CCR_Load,ALU_Sel,Bus1_Sel,Bus2_Sel,write}
    logic [14:0] w_obs;
    assign w_obs = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
                    ALU_Sel, Bus1_Sel, Bus2_Sel, write};

    localparam logic [14:0] c_NONE   = 15'h0000;
    localparam logic [14:0] c_MARPC  = 15'h2002;  // MAR_Load, Bus1=PC, Bus2=Bus1
    localparam logic [14:0] c_PCINC  = 15'h0800;
    localparam logic [14:0] c_IRLD   = 15'h4004;  // IR_Load, Bus2=mem
    localparam logic [14:0] c_LDA    = 15'h0404;  // A_Load, Bus2=mem
    localparam logic [14:0] c_LDB    = 15'h0204;  // B_Load, Bus2=mem
    localparam logic [14:0] c_MARMEM = 15'h2004;  // MAR_Load, Bus2=mem
    localparam logic [14:0] c_STA    = 15'h0009;  // Bus1=A, write
    localparam logic [14:0] c_STB    = 15'h0011;  // Bus1=B, write
    localparam logic [14:0] c_ADD    = 15'h0510;  // A_Load, CCR_Load, Bus1=B, ALU 000
    localparam logic [14:0] c_SUB    = 15'h0550;  // ... ALU 010
    localparam logic [14:0] c_AND    = 15'h0590;  // ... ALU 100
    localparam logic [14:0] c_OR     = 15'h05B0;  // ... ALU 101
    localparam logic [14:0] c_PCLD   = 15'h1004;  // PC_Load, Bus2=mem

    task automatic check(input logic [14:0] exp, input string tag);
        #1;
        n_checks++;
        assert (w_obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, w_obs, exp);
        end
    endtask

    task automatic step(input logic [14:0] exp, input string tag);
        check(exp, tag);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [7:0] op, input logic [3:0] ccr);
        IR         = op;
        CCR_Result = ccr;
        step(c_MARPC, "fetch0");
        step(c_PCINC, "fetch1");
        step(c_IRLD,  "fetch2");
        step(c_NONE,  "decode3");
    endtask

    initial begin
        reset      = 1'b1;
        IR         = 8'h00;
        CCR_Result = 4'h0;
        check(c_NONE, "reset_before_clk");
        @(posedge clk);
        @(negedge clk);
        check(c_NONE, "reset_held");
        @(negedge clk);
        reset = 1'b0;

        fetch(8'h86, 4'h0);
        step(c_MARPC,  "lda_imm_s4");
        step(c_PCINC,  "lda_imm_s5");
        step(c_LDA,    "lda_imm_s6");

        fetch(8'h88, 4'h0);
        step(c_MARPC,  "ldb_imm_s4");
        step(c_PCINC,  "ldb_imm_s5");
        step(c_LDB,    "ldb_imm_s6");

        fetch(8'h87, 4'h0);
        step(c_MARPC,  "lda_dir_s4");
        step(c_PCINC,  "lda_dir_s5");
        step(c_MARMEM, "lda_dir_s6");
        step(c_NONE,   "lda_dir_s7");
        step(c_LDA,    "lda_dir_s8");

        fetch(8'h89, 4'h0);
        step(c_MARPC,  "ldb_dir_s4");
        step(c_PCINC,  "ldb_dir_s5");
        step(c_MARMEM, "ldb_dir_s6");
        step(c_NONE,   "ldb_dir_s7");
        step(c_LDB,    "ldb_dir_s8");

        fetch(8'h96, 4'h0);
        step(c_MARPC,  "sta_s4");
        step(c_PCINC,  "sta_s5");
        step(c_MARMEM, "sta_s6");
        step(c_STA,    "sta_s7");

        fetch(8'h97, 4'h0);
        step(c_MARPC,  "stb_s4");
        step(c_PCINC,  "stb_s5");
        step(c_MARMEM, "stb_s6");
        step(c_STB,    "stb_s7");

        fetch(8'h42, 4'h0);
        step(c_ADD, "add_s4");
        fetch(8'h43, 4'h0);
        step(c_SUB, "sub_s4");
        fetch(8'h44, 4'h0);
        step(c_AND, "and_s4");
        fetch(8'h45, 4'h0);
        step(c_OR,  "or_s4");

        fetch(8'h20, 4'h0);
        step(c_MARPC, "bra_s4");
        step(c_NONE,  "bra_s5");
        step(c_PCLD,  "bra_s6");

`ifdef BRANCH_COND_EN
        // Flags change after decode; the latched decision must hold
        fetch(8'h23, 4'b0100);
        CCR_Result = 4'b0000;
        step(c_MARPC, "beq_taken_s4");
        step(c_NONE,  "beq_taken_s5");
        step(c_PCLD,  "beq_taken_s6");

        fetch(8'h23, 4'b0000);
        CCR_Result = 4'b0100;
        step(c_PCINC, "beq_nt_s4");

        fetch(8'h21, 4'b1000);
        step(c_MARPC, "bmi_taken_s4");
        step(c_NONE,  "bmi_taken_s5");
        step(c_PCLD,  "bmi_taken_s6");

        fetch(8'h21, 4'b0100);
        step(c_PCINC, "bmi_nt_s4");
`else
        // Conditional branches behave as unknown opcodes: decode then fetch
        fetch(8'h23, 4'b0100);
        fetch(8'h23, 4'b0000);
        fetch(8'h21, 4'b1000);
`endif

        fetch(8'hFF, 4'h0);

        // Reset pulse in the middle of LDA_DIR S7
        fetch(8'h87, 4'h0);
        step(c_MARPC,  "lda_dir2_s4");
        step(c_PCINC,  "lda_dir2_s5");
        step(c_MARMEM, "lda_dir2_s6");
        check(c_NONE,  "lda_dir2_s7");
        #2;
        reset = 1'b1;
        check(c_NONE, "reset_async_mid");
        @(posedge clk);
        @(negedge clk);
        check(c_NONE, "reset_mid_held1");
        @(posedge clk);
        @(negedge clk);
        check(c_NONE, "reset_mid_held2");
        @(negedge clk);
        reset = 1'b0;
        step(c_MARPC, "post_reset_fetch0");
        step(c_PCINC, "post_reset_fetch1");
        check(c_IRLD, "post_reset_fetch2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
